mem_port_arbiter: RTL

Two-requester arbiter and access sequencer for the single-ported data/IO memory behind the load-store path. Port 0 serves the core's load/store unit. Port 1 serves a secondary master (debug loader or DMA). The block round-robins between the ports, holds one access stable on the memory side for a programmable number of wait states, and returns a registered one-cycle response pulse to the winning port.

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-port round-robin arbiter in front of a single-ported data/IO memory.
// Port 0 is the load/store unit, port 1 a secondary master (debug loader or
// DMA). One access is held stable on the memory side for WAIT_CYCLES extra
// cycles, then a registered one-cycle response pulse goes back to the port
// that won.
module mem_port_arbiter #(
    parameter int Width       = 32,
    parameter int AddrW       = 12,
    parameter int WAIT_CYCLES = 0     // legal range 0..7
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    // Requester side, bit/port p belongs to requester p
    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  logic [1:0]           req_we_i,
    input  logic [AddrW-1:0]     req_addr0_i,
    input  logic [AddrW-1:0]     req_addr1_i,
    input  logic [Width-1:0]     req_wdata0_i,
    input  logic [Width-1:0]     req_wdata1_i,
    input  logic [Width/8-1:0]   req_wstrb0_i,
    input  logic [Width/8-1:0]   req_wstrb1_i,

    // Response side, read data shared by both ports
    output logic [1:0]           rsp_valid_o,
    output logic [Width-1:0]     rsp_rdata_o,

    // Memory side
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [AddrW-1:0]     mem_addr_o,
    output logic [Width-1:0]     mem_wdata_o,
    output logic [Width/8-1:0]   mem_wstrb_o,
    input  logic [Width-1:0]     mem_rdata_i
);

    localparam int StrbW = Width / 8;

    // Wait-state counter reload value; the counter is 3 bits wide because
    // WAIT_CYCLES never exceeds 7.
    localparam logic [2:0] WaitInit = 3'(WAIT_CYCLES);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         wcnt_q, wcnt_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_q, grant_d;      // port currently being served

    // Latched request payload, presented to memory during ACCESS
    logic               we_q;
    logic [AddrW-1:0]   addr_q;
    logic [Width-1:0]   wdata_q;
    logic [StrbW-1:0]   wstrb_q;

    // Registered response
    logic [1:0]         rsp_valid_q;
    logic [Width-1:0]   rsp_rdata_q;

    logic               any_valid;
    logic               winner;
    logic               handshake;
    logic               final_beat;

    // Round-robin winner selection and the IDLE-only ready handshake.
    always_comb begin
        any_valid  = |req_valid_i;
        // On a tie the port that did not win last time goes first; with a
        // single requester that requester wins outright.
        winner     = (&req_valid_i) ? ~last_grant_q : req_valid_i[1];
        handshake  = (state_q == IDLE) && any_valid && !rst_i;
        final_beat = (state_q == ACCESS) && (wcnt_q == 3'd0);

        req_ready_o = 2'b00;
        if (handshake) begin
            req_ready_o = winner ? 2'b10 : 2'b01;
        end
    end

    // Next-state logic: grant in IDLE, count wait states in ACCESS.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d      = ACCESS;
                    wcnt_d       = WaitInit;
                    grant_d      = winner;
                    last_grant_d = winner;
                end
            end
            ACCESS: begin
                if (wcnt_q != 3'd0) begin
                    wcnt_d = wcnt_q - 3'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, counter and arbitration history registers.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (rst_i) begin
            state_q      <= IDLE;
            wcnt_q       <= 3'd0;
            last_grant_q <= 1'b1;   // port 0 wins the first tie
            grant_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    // Capture the winner's payload on the handshake edge; it stays put for
    // the whole access.
    always_ff @(posedge clk_i) begin
        // NOTE: these are plain registers, not a memory array, so they are
        // reset to give the memory port a defined value after reset.
        if (rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (handshake) begin
            we_q    <= winner ? req_we_i[1]  : req_we_i[0];
            addr_q  <= winner ? req_addr1_i  : req_addr0_i;
            wdata_q <= winner ? req_wdata1_i : req_wdata0_i;
            wstrb_q <= winner ? req_wstrb1_i : req_wstrb0_i;
        end
    end

    // Response pulse and read data, registered at the end of the final
    // access cycle. Read data holds until the next response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 2'b00;
            if (final_beat) begin
                rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
                rsp_rdata_q <= we_q ? '0 : mem_rdata_i;
            end
        end
    end

    // Memory-side drive. Enable is gated by reset in the same cycle so an
    // access aborted by reset never commits a write.
    always_comb begin
        mem_en_o    = (state_q == ACCESS) && !rst_i;
        mem_we_o    = mem_en_o && we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_wstrb_o = wstrb_q;
        rsp_valid_o = rsp_valid_q;
        rsp_rdata_o = rsp_rdata_q;
    end

endmodule
